// File: rtl/svm_pkg.sv
// Shared state encoding, default sizing and the element/product extension helper
// for the linear-SVM decision engine.
package svm_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    READ  = 2'd1,
    MAC   = 2'd2,
    JUDGE = 2'd3
  } state_e;

  localparam int LANES_DFLT   = 16;
  localparam int LANE_W_DFLT  = 8;
  localparam int COEF_W_DFLT  = 16;
  localparam int ACC_W_DFLT   = 48;
  localparam int WORDS        = 32;
  localparam int VEC_LEN_DFLT = WORDS * LANES_DFLT;
  localparam int PROD_W       = LANE_W_DFLT + 1 + COEF_W_DFLT;
  localparam int ADDR_W       = $clog2(VEC_LEN_DFLT);

  // Extends the low w bits of v to 64 bits, sign- or zero-filling above bit w-1.
  function automatic logic [63:0] ext(input logic [63:0] v, input int w, input logic sgn);
    logic [63:0] mask;
    logic        sb;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    sb   = sgn & (|(v & (64'd1 << (w - 1))));
    return (v & mask) | ({64{sb}} & ~mask);
  endfunction

endpackage

// File: rtl/svm_linear_classifier_coef_ram.sv
// Coefficient store: one bank per lane so a whole word of coefficients is read
// combinationally for the word being accumulated; single write port.
module svm_coef_ram
  import svm_pkg::*;
#(
  parameter int COEF_W = COEF_W_DFLT,
  parameter int LANES  = LANES_DFLT,
  parameter int NWORDS = WORDS,
  parameter int AW     = ADDR_W,
  parameter int CNT_W  = 5
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [AW-1:0]           addr_i,
  input  logic [COEF_W-1:0]       wdata_i,
  input  logic [CNT_W-1:0]        rd_word_i,
  output logic [LANES*COEF_W-1:0] rdata_o
);

  logic [CNT_W-1:0] wr_word;
  logic [AW-1:0]    wr_lane;

  assign wr_word = CNT_W'(addr_i / AW'(LANES));
  assign wr_lane = addr_i % AW'(LANES);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_bank
      logic [COEF_W-1:0] mem [NWORDS];

      // Writes are not gated by reset or clock enable: the store survives both.
      always_ff @(posedge clk_i) begin
        if (we_i && (wr_lane == AW'(gi))) begin
          mem[wr_word] <= wdata_i;
        end
      end

      assign rdata_o[gi*COEF_W +: COEF_W] = mem[rd_word_i];
    end
  endgenerate

endmodule

// File: rtl/svm_linear_classifier.sv
// Linear-SVM decision engine: pops LANES-wide words, accumulates the weighted dot
// product against the coefficient store, adds bias and thresholds once per vector.
module svm_linear_classifier
  import svm_pkg::*;
#(
  parameter int LANES       = LANES_DFLT,
  parameter int LANE_W      = LANE_W_DFLT,
  parameter int COEF_W      = COEF_W_DFLT,
  parameter int ACC_W       = ACC_W_DFLT,
  parameter int VEC_LEN     = VEC_LEN_DFLT,
  parameter int SIGNED_DATA = 0,
  localparam int N_WORDS    = VEC_LEN / LANES,
  localparam int N_PROD_W   = LANE_W + 1 + COEF_W,
  localparam int N_ADDR_W   = $clog2(VEC_LEN),
  localparam int CNT_W      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    ce_i,
  input  logic                    restart_i,
  input  logic [LANES*LANE_W-1:0] rddata_i,
  input  logic                    rdempty_i,
  output logic                    rdfifo_o,
  input  logic                    coef_we_i,
  input  logic [N_ADDR_W-1:0]     coef_addr_i,
  input  logic [COEF_W-1:0]       coef_wdata_i,
  input  logic [ACC_W-1:0]        bias_i,
  input  logic [ACC_W-1:0]        threshold_i,
  output logic                    objecttype_o,
  output logic                    objecttypeready_o,
  output logic [ACC_W-1:0]        score_o,
  output logic                    busy_o
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [ACC_W-1:0]        score_q;
  logic                    objecttype_q;
  logic                    ready_q;
  logic                    pop, capture, judge;
  logic [ACC_W-1:0]        judged;
  logic [ACC_W-1:0]        dot;
  logic [LANES*COEF_W-1:0] coef_flat;
  logic signed [N_PROD_W-1:0] prod [LANES];

  svm_coef_ram #(
    .COEF_W (COEF_W),
    .LANES  (LANES),
    .NWORDS (N_WORDS),
    .AW     (N_ADDR_W),
    .CNT_W  (CNT_W)
  ) u_coef_ram (
    .clk_i     (clk_i),
    .we_i      (coef_we_i),
    .addr_i    (coef_addr_i),
    .wdata_i   (coef_wdata_i),
    .rd_word_i (cnt_q),
    .rdata_o   (coef_flat)
  );

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0]        lane_q;
      logic signed [LANE_W:0]   elem;
      logic signed [COEF_W-1:0] coef;

      always_ff @(posedge clk_i) begin
        if (reset_ni && ce_i && capture) begin
          lane_q <= rddata_i[gi*LANE_W +: LANE_W];
        end
      end

      assign elem     = (LANE_W + 1)'(ext(64'(lane_q), LANE_W, SIGNED_DATA != 0));
      assign coef     = coef_flat[gi*COEF_W +: COEF_W];
      assign prod[gi] = N_PROD_W'(elem) * N_PROD_W'(coef);
    end
  endgenerate

  // Unregistered adder tree; every product is sign-extended to the accumulator width.
  always_comb begin
    dot = '0;
    for (int l = 0; l < LANES; l++) begin
      dot = dot + ACC_W'(ext(64'(prod[l]), N_PROD_W, 1'b1));
    end
  end

  assign judged = acc_q + bias_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pop     = 1'b0;
    capture = 1'b0;
    judge   = 1'b0;
    if (restart_i) begin
      state_d = WAIT;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        WAIT: begin
          if (!rdempty_i) begin
            pop     = 1'b1;
            state_d = READ;
          end
        end
        READ: begin
          capture = 1'b1;
          state_d = MAC;
        end
        MAC: begin
          acc_d   = acc_q + dot;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q == LAST_WORD) ? JUDGE : WAIT;
        end
        JUDGE: begin
          judge   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = WAIT;
        end
        default: state_d = WAIT;
      endcase
    end
  end

  // The ready pulse is refreshed every cycle so a frozen clock enable cannot stretch it.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= WAIT;
      cnt_q        <= '0;
      acc_q        <= '0;
      score_q      <= '0;
      objecttype_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      ready_q <= ce_i & judge;
      if (ce_i) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        acc_q   <= acc_d;
        if (judge) begin
          score_q      <= judged;
          objecttype_q <= $signed(judged) > $signed(threshold_i);
        end
      end
    end
  end

  assign rdfifo_o          = pop & ce_i & reset_ni;
  assign objecttype_o      = objecttype_q;
  assign objecttypeready_o = ready_q;
  assign score_o           = score_q;
  assign busy_o            = (cnt_q != '0) || (state_q != WAIT);

endmodule
